// File: rtl/sar_adc_pkg.sv
// Purpose: shared constants and state type for the SAR ADC capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sar_adc_pkg;

   // Default DAC / result width in bits.
   localparam int SAR_WIDTH       = 8;
   // Default comparator synchronizer depth.
   localparam int SAR_SYNC_STAGES = 2;
   // The phase counter must reach S + SYNC_STAGES = 257 when S = 255, so 9 bits.
   localparam int PHASE_CNT_W     = 9;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      FINISH
   } state_t;

endpackage

// File: rtl/sync_ff.sv
// Purpose: STAGES-deep flop chain bringing an async pad input into the clk domain.
// Latency: STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high reset, clears every stage to 0
//   d   - asynchronous input
//   q   - synchronized output (last stage of the chain)
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sar_adc_control.sv
// Purpose: successive-approximation controller driving the R2R DAC and binary-searching the comparator.
// Latency: 8*(settle_cycles + SYNC_STAGES + 1) cycles from the start edge to the done pulse.
// Backpressure: none; start is ignored while busy or finishing, nothing is queued.
//
// Ports:
//   clk           - system clock
//   rst           - synchronous active-high reset (priority over start/continuous)
//   start         - begin a conversion, honoured only in IDLE
//   continuous    - relaunch automatically when a conversion completes
//   settle_cycles - extra DAC settle cycles per bit, latched at conversion start
//   comp_in       - async comparator, 1 when Vin >= Vdac
//   r2r_out       - trial / final code to the DAC
//   result        - last completed conversion
//   busy          - conversion in progress (stays high across continuous relaunches)
//   done          - one-cycle pulse when result is updated
module sar_adc_control
   import sar_adc_pkg::*;
#(
   parameter int WIDTH       = SAR_WIDTH,
   parameter int SYNC_STAGES = SAR_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic [7:0]       settle_cycles,
   input  logic             comp_in,
   output logic [WIDTH-1:0] r2r_out,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   state_t                 state, state_n;
   logic [PTR_W-1:0]       ptr, ptr_n;
   logic [PHASE_CNT_W-1:0] cnt, cnt_n;
   logic [7:0]             s_lat, s_lat_n;
   logic [WIDTH-1:0]       r2r_q, r2r_n;
   logic [WIDTH-1:0]       result_q, result_n;
   logic                   busy_q, busy_n;
   logic                   done_q, done_n;

   logic                   comp_s;
   logic                   phase_last;
   logic                   launch;
   logic [WIDTH-1:0]       trial;

   sync_ff #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_comp_sync (
      .clk (clk),
      .rst (rst),
      .d   (comp_in),
      .q   (comp_s)
   );

   // The last cycle of a bit phase is when cnt == T-1 = S + SYNC_STAGES;
   // by then comp_s reflects the comparator response to the current trial.
   assign phase_last = (cnt == ({1'b0, s_lat} + PHASE_CNT_W'(SYNC_STAGES)));

   // A new conversion begins from IDLE on start, or straight out of FINISH
   // in continuous mode (busy never drops in that case).
   assign launch = ((state == IDLE) && start) || ((state == FINISH) && continuous);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         s_lat    <= '0;
         r2r_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         cnt      <= cnt_n;
         s_lat    <= s_lat_n;
         r2r_q    <= r2r_n;
         result_q <= result_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      cnt_n    = cnt;
      s_lat_n  = s_lat;
      r2r_n    = r2r_q;
      result_n = result_q;
      busy_n   = busy_q;
      done_n   = 1'b0;

      // Decided code for the current bit, with the next lower bit raised as
      // the following trial. Only bit set/clear, no arithmetic on the code.
      trial      = r2r_q;
      trial[ptr] = comp_s;
      if (ptr != '0) begin
         trial[ptr - PTR_W'(1)] = 1'b1;
      end

      case (state)
         IDLE: begin
            // r2r_out and result hold the last final code.
         end

         CONVERT: begin
            if (phase_last) begin
               cnt_n = '0;
               r2r_n = trial;
               if (ptr == '0) begin
                  result_n = trial;
                  done_n   = 1'b1;
                  state_n  = FINISH;
               end else begin
                  ptr_n = ptr - PTR_W'(1);
               end
            end else begin
               cnt_n = cnt + PHASE_CNT_W'(1);
            end
         end

         FINISH: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end

         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase

      if (launch) begin
         state_n = CONVERT;
         s_lat_n = settle_cycles;
         ptr_n   = PTR_W'(WIDTH - 1);
         cnt_n   = '0;
         r2r_n   = MSB_CODE;
         busy_n  = 1'b1;
      end
   end

   assign r2r_out = r2r_q;
   assign result  = result_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sar_adc_control.sv
// Purpose: self-checking bench for sar_adc_control with an ideal comparator and timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sar_adc_control;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst;
   logic       start;
   logic       continuous;
   logic [7:0] settle_cycles;
   logic       comp_in;
   logic [7:0] r2r_out;
   logic [7:0] result;
   logic       busy;
   logic       done;

   logic [7:0] vin;

   int n_vec;
   int n_err;

   sar_adc_control #(
      .WIDTH       (8),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .continuous    (continuous),
      .settle_cycles (settle_cycles),
      .comp_in       (comp_in),
      .r2r_out       (r2r_out),
      .result        (result),
      .busy          (busy),
      .done          (done)
   );

   // Ideal zero-delay comparator.
   assign comp_in = (vin >= r2r_out);

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A conversion is a timeline: k cycles after the launch edge, the DAC shows
   // the binary-search trial for bit 7 - k/T (upper bits already equal to vin),
   // and at k = 8T the final code (= vin for an ideal comparator) appears with done.
   logic       m_valid;
   logic       m_active;
   logic       m_fin;
   int         m_k;
   int         m_S;
   int         m_vin;
   logic [7:0] e_r2r;
   logic [7:0] e_res;
   logic       e_busy;
   logic       e_done;

   function automatic logic [7:0] trial_code(input int v, input int b);
      return 8'(((v >> (b + 1)) << (b + 1)) | (1 << b));
   endfunction

   task automatic m_launch();
      m_S      = int'(settle_cycles);
      m_vin    = int'(vin);
      m_k      = 0;
      m_active = 1'b1;
      e_r2r    = 8'h80;
      e_busy   = 1'b1;
      e_done   = 1'b0;
   endtask

   task automatic model_step();
      int t;
      if (rst) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_fin    = 1'b0;
         e_r2r    = 8'h00;
         e_res    = 8'h00;
         e_busy   = 1'b0;
         e_done   = 1'b0;
      end else if (!m_valid) begin
         m_active = 1'b0;
      end else if (m_fin) begin
         m_fin  = 1'b0;
         e_done = 1'b0;
         if (continuous) begin
            m_launch();
         end else begin
            m_active = 1'b0;
            e_busy   = 1'b0;
         end
      end else if (m_active) begin
         m_k++;
         t = m_S + SYNC + 1;
         if (m_k == 8 * t) begin
            e_r2r  = 8'(m_vin);
            e_res  = 8'(m_vin);
            e_done = 1'b1;
            m_fin  = 1'b1;
         end else begin
            e_r2r = trial_code(m_vin, 7 - m_k / t);
         end
      end else if (start) begin
         m_launch();
      end
   endtask

   initial begin
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Per-cycle compare of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("r2r_out", r2r_out, e_r2r);
            chk("result",  result,  e_res);
            chk("busy",    busy,    e_busy);
            chk("done",    done,    e_done);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the launch edge until done is seen; also counts
   // cycles where busy was low on the way.
   task automatic wait_done(input int budget, output int cyc, output int blow);
      cyc  = 0;
      blow = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy !== 1'b1) blow++;
      end while (done !== 1'b1 && cyc < budget);
      if (done !== 1'b1) chk("done_timeout", 32'(cyc), 32'(budget + 1));
   endtask

   logic [7:0] exp1 [8];
   logic [7:0] bvin [3];

   initial begin
      int cyc, blow, ndone, first;

      exp1 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      bvin = '{8'h00, 8'hFF, 8'h80};
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      settle_cycles = 8'd0;
      vin = 8'h00;

      // Reset state
      step(3);
      chk("rst_r2r",    r2r_out, 8'h00);
      chk("rst_result", result,  8'h00);
      chk("rst_busy",   busy,    1'b0);
      chk("rst_done",   done,    1'b0);
      rst = 1'b0;
      step(2);

      // 1: trial sequence for 0xA5, settle 0
      vin = 8'hA5;
      settle_cycles = 8'd0;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         chk("t1_trial", r2r_out, exp1[i]);
         step(3);
      end
      chk("t1_done",   done,   1'b1);
      chk("t1_result", result, 8'hA5);
      step(1);
      chk("t1_busy_low", busy, 1'b0);
      chk("t1_done_low", done, 1'b0);
      step(2);

      // 2: boundary codes
      for (int i = 0; i < 3; i++) begin
         vin = bvin[i];
         pulse_start();
         wait_done(100, cyc, blow);
         chk("t2_latency", 32'(cyc), 32'd24);
         chk("t2_result", result, bvin[i]);
         step(2);
      end

      // 3: settle 5 and settle 255
      vin = 8'h3C;
      settle_cycles = 8'd5;
      pulse_start();
      wait_done(200, cyc, blow);
      chk("t3_latency_s5", 32'(cyc), 32'd64);
      chk("t3_result_s5", result, 8'h3C);
      step(2);
      vin = 8'hC3;
      settle_cycles = 8'd255;
      pulse_start();
      wait_done(3000, cyc, blow);
      chk("t3_latency_s255", 32'(cyc), 32'd2064);
      chk("t3_result_s255", result, 8'hC3);
      step(2);

      // 4: start during busy and settle change mid-conversion
      vin = 8'h5A;
      settle_cycles = 8'd0;
      pulse_start();
      cyc = 0;
      ndone = 0;
      first = -1;
      while (cyc < 40) begin
         if (cyc == 9) begin
            start = 1'b1;
            settle_cycles = 8'd7;
         end
         if (cyc == 10) start = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
         if (done === 1'b1) begin
            ndone++;
            if (first < 0) first = cyc;
         end
      end
      chk("t4_done_count", 32'(ndone), 32'd1);
      chk("t4_done_cycle", 32'(first), 32'd24);
      chk("t4_result", result, 8'h5A);
      settle_cycles = 8'd0;
      step(1);

      // 5: reset mid-conversion
      vin = 8'h77;
      pulse_start();
      step(11);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("t5_r2r",    r2r_out, 8'h00);
      chk("t5_result", result,  8'h00);
      chk("t5_busy",   busy,    1'b0);
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (done === 1'b1) ndone++;
      end
      chk("t5_no_done", 32'(ndone), 32'd0);
      vin = 8'h33;
      pulse_start();
      wait_done(100, cyc, blow);
      chk("t5_restart_latency", 32'(cyc), 32'd24);
      chk("t5_restart_result", result, 8'h33);
      step(2);

      // 6: continuous mode
      continuous = 1'b1;
      vin = 8'h10;
      pulse_start();
      wait_done(100, cyc, blow);
      chk("t6_first_latency", 32'(cyc), 32'd24);
      chk("t6_first_result", result, 8'h10);
      chk("t6_first_busy", 32'(blow), 32'd0);
      vin = 8'hF0;
      wait_done(100, cyc, blow);
      chk("t6_spacing", 32'(cyc), 32'd25);
      chk("t6_second_result", result, 8'hF0);
      chk("t6_busy_held", 32'(blow), 32'd0);
      continuous = 1'b0;
      step(1);
      chk("t6_busy_falls", busy, 1'b0);
      step(2);

      // Randomized traffic against the model
      for (int it = 0; it < 30; it++) begin
         int n;
         n = int'($urandom_range(10, 70));
         for (int c = 0; c < n; c++) begin
            if (busy !== 1'b1 || done === 1'b1) vin = 8'($urandom_range(0, 255));
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
               settle_cycles = 8'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 40)
                                                               : $urandom_range(0, 6));
            end
            if ($urandom_range(0, 5) == 0) continuous = ~continuous;
            rst = ($urandom_range(0, 199) == 0);
            step(1);
         end
      end
      start = 1'b0;
      rst = 1'b0;
      continuous = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 3000) begin
         step(1);
         cyc++;
      end
      chk("drain_idle", busy, 1'b0);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sar_adc_control.md
Name: sar_adc_control

Overview:
- Successive-approximation ADC controller; the capture side of the existing R2R DAC path.
- Drives trial codes onto the 8-bit R2R DAC, samples an external comparator (analog input vs DAC output), and binary-searches an 8-bit result.
- Sits beside the DAC control block on the same R2R pins; top-level muxing selects which block owns the DAC.

Parameters:
- WIDTH, 8, DAC/result width in bits.
- SYNC_STAGES, 2, comparator synchronizer depth.

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a conversion; honoured only in IDLE.
- continuous  input  1  when high, a new conversion starts automatically on completion.
- settle_cycles  input  8  extra DAC settle cycles per bit; latched at conversion start.
- comp_in  input  1  async comparator output; 1 = Vin >= Vdac.
- r2r_out  output  WIDTH  trial/final code to the R2R DAC.
- result  output  WIDTH  last completed conversion.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse, result updated.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: r2r_out=0, result=0, busy=0, done=0, state IDLE, synchronizer flops 0.
- comp_in passes through a SYNC_STAGES flop chain before use (comp_s). All timing below includes this chain.
- States: IDLE, CONVERT, FINISH.
- IDLE to CONVERT on the edge where start=1:
  - latch S=settle_cycles;
  - bit pointer = WIDTH-1;
  - r2r_out=0x80;
  - busy=1;
  - phase counter=0.
- Bit phase length T = S + SYNC_STAGES + 1 cycles.
  - The phase counter increments each cycle.
  - On the edge where counter == T-1, sample comp_s:
    - comp_s=1: keep the current trial bit.
    - comp_s=0: clear the current trial bit.
  - On the same edge, set the next lower bit, reset the counter, and decrement the pointer.
- The decision on bit 0 (edge 8T after start):
  - result <= final code;
  - r2r_out holds the final code;
  - done=1 for exactly one cycle;
  - state goes to FINISH for that one cycle.
- FINISH exit:
  - continuous=1 at the edge leaving FINISH: behave as if start=1 (re-latch settle_cycles, r2r_out=0x80, busy stays 1).
  - Otherwise: to IDLE with busy=0.
  - The busy low-pulse is therefore absent in continuous mode.
- IDLE: r2r_out and result hold the last final code.
- start asserted while busy or in FINISH: ignored (no restart, no queueing).
- Changing settle_cycles mid-conversion has no effect until the next start.
- rst asserted mid-conversion: immediate return to reset values on that edge; no done pulse. The partial code is discarded.
- rst has priority over start and continuous.
- Width rules:
  - Phase counter is 9 bits wide so that S=255 is handled (T=258).
  - No arithmetic on codes beyond bit set/clear.

Decomposition:
- Shared package sar_adc_pkg:
  - WIDTH default;
  - SYNC_STAGES;
  - state enum {IDLE, CONVERT, FINISH};
  - phase-counter width constant.
- One sub-module, sync_ff, a SYNC_STAGES-deep synchronizer with synchronous reset. It is reusable for other async pad inputs.
- Everything else is inline in sar_adc_control.

Test Plan:
- Behavioral comparator model for all scenarios: comp_in = (vin >= r2r_out), applied with zero delay.
1. settle_cycles=0, vin=0xA5, pulse start: trial codes are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. done pulses 24 cycles after the start edge, result=0xA5, busy low the following cycle.
2. Boundaries:
   - vin=0x00 gives result 0x00.
   - vin=0xFF gives result 0xFF.
   - vin=0x80 gives 0x80.
   - All complete in 24 cycles with settle_cycles=0.
3. settle_cycles=5, vin=0x3C: done exactly 64 cycles after start, result 0x3C. With settle_cycles=255, done after 8×258 cycles.
4. Start during busy and settle_cycles change:
   - Pulse start again at cycle 10 of a conversion: no restart, single done at cycle 24.
   - Change settle_cycles mid-conversion: timing unchanged.
5. Reset mid-conversion: rst at cycle 12. r2r_out=0, result=0, busy=0 next cycle, no done. A new start then converts normally.
6. Continuous mode:
   - continuous=1, vin stepping 0x10 then 0xF0: back-to-back done pulses 25 cycles apart (settle 0) with results 0x10 then 0xF0.
   - busy never drops while continuous=1.
   - Clear continuous: busy falls after the final done.
